// File: rtl/arb_pkg.sv
// Arbitration mode, FSM state encoding and index-width helper for mem_arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,   // port 0 always has highest priority
        ARB_RR    = 1'b1    // round-robin starting after the last grant
    } arb_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Width of a port index; never narrower than one bit.
    function automatic int idx_width(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

endpackage : arb_pkg

// File: rtl/type_pkg.sv
// Shared bus field types for the unified-memory arbiter and its requesters.
package type_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [BE_W-1:0]   byte_en_t;

endpackage : type_pkg

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bundles of the arbiter.
// arb_req_if: requesters are the master, the arbiter is the slave.
// arb_mem_if: the arbiter is the master, the unified memory is the slave.
interface arb_req_if #(
    parameter int N_PORTS = 2
);
    import type_pkg::*;

    logic     [N_PORTS-1:0] req_valid;
    addr_t    [N_PORTS-1:0] req_addr;
    data_t    [N_PORTS-1:0] req_wdata;
    byte_en_t [N_PORTS-1:0] req_byte_enable;   // all-zero means read
    logic     [N_PORTS-1:0] req_ready;         // one-hot completion pulse
    data_t                  req_rdata;         // shared, zero when no ready

    modport master (
        output req_valid, req_addr, req_wdata, req_byte_enable,
        input  req_ready, req_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_byte_enable,
        output req_ready, req_rdata
    );
endinterface : arb_req_if

interface arb_mem_if;
    import type_pkg::*;

    logic     mem_valid;
    addr_t    mem_addr;
    data_t    mem_wdata;
    byte_en_t mem_byte_enable;
    logic     mem_ready;
    data_t    mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_byte_enable,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_byte_enable,
        output mem_ready, mem_rdata
    );
endinterface : arb_mem_if

// File: rtl/rr_picker.sv
// Combinational winner selection. In fixed mode the search starts at port 0;
// in round-robin mode it starts one past the last grant and wraps around.
module rr_picker
    import arb_pkg::*;
#(
    parameter  int N_PORTS = 2,
    localparam int IDX_W   = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req_vec_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    input  arb_mode_t          mode_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               found_o
);

    int               start;
    logic [IDX_W-1:0] cand;

    // Scan the request vector from the mode-dependent start point; first hit wins.
    always_comb begin
        // NOTE: every output and temporary gets a default before the scan so no path infers a latch.
        winner_o = '0;
        found_o  = 1'b0;
        cand     = '0;
        start    = (mode_i == ARB_RR) ? (int'(last_grant_i) + 1) % N_PORTS : 0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = IDX_W'((start + k) % N_PORTS);
            if (!found_o && req_vec_i[cand]) begin
                winner_o = cand;
                found_o  = 1'b1;
            end
        end
    end

endmodule : rr_picker

// File: rtl/mem_arbiter.sv
// Arbitrates N_PORTS requesters onto one unified memory port.
// One transaction at a time: IDLE picks a winner and latches its fields,
// BUSY holds them on the memory bus until mem_ready, then returns to IDLE.
// The mandatory IDLE cycle between transactions gives requesters time to
// drop req_valid after their ready pulse.
module mem_arbiter
    import arb_pkg::*;
    import type_pkg::*;
#(
    parameter  int        N_PORTS  = 2,          // legal range 2..8
    parameter  arb_mode_t ARB_MODE = ARB_FIXED,
    localparam int        IDX_W    = idx_width(N_PORTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    arb_req_if.slave         req,
    arb_mem_if.master        mem,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    addr_t            addr_q, addr_d;
    data_t            wdata_q, wdata_d;
    byte_en_t         be_q, be_d;

    logic [IDX_W-1:0] winner;
    logic             found;

    rr_picker #(
        .N_PORTS (N_PORTS)
    ) u_picker (
        .req_vec_i    (req.req_valid),
        .last_grant_i (last_grant_q),
        .mode_i       (ARB_MODE),
        .winner_o     (winner),
        .found_o      (found)
    );

    // State and latched-request registers; last_grant resets to the top
    // port so the first round-robin search begins at port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(N_PORTS - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

    // Next-state logic and the combinational completion handshake.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        req.req_ready = '0;
        req.req_rdata = '0;

        case (state_q)
            IDLE: begin
                // mem_ready arriving here is a stray pulse and is ignored.
                if (found) begin
                    state_d      = BUSY;
                    grant_d      = winner;
                    last_grant_d = winner;
                    addr_d       = req.req_addr[winner];
                    wdata_d      = req.req_wdata[winner];
                    be_d         = req.req_byte_enable[winner];
                end
            end
            BUSY: begin
                // The transaction completes even if the granted port has
                // since dropped req_valid; its ready still pulses.
                if (mem.mem_ready) begin
                    state_d                = IDLE;
                    req.req_ready[grant_q] = 1'b1;
                    req.req_rdata          = mem.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem.mem_valid       = (state_q == BUSY);
    assign mem.mem_addr        = addr_q;
    assign mem.mem_wdata       = wdata_q;
    assign mem.mem_byte_enable = be_q;
    assign grant_idx           = grant_q;
    assign busy                = (state_q == BUSY);

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a fixed-priority 2-port instance and a
// round-robin 4-port instance, each with its own memory responder and monitor.
module tb_mem_arbiter;
    import type_pkg::*;
    import arb_pkg::*;

    localparam int  NF    = 2;
    localparam int  NR    = 4;
    localparam time CLK_P = 10;

    typedef struct {
        int    port;
        data_t rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #(CLK_P / 2) clk = ~clk;

    arb_req_if #(.N_PORTS(NF)) req_f ();
    arb_mem_if                 mem_f ();
    arb_req_if #(.N_PORTS(NR)) req_r ();
    arb_mem_if                 mem_r ();

    logic [0:0] grant_f;
    logic       busy_f;
    logic [1:0] grant_r;
    logic       busy_r;

    mem_arbiter #(.N_PORTS(NF), .ARB_MODE(ARB_FIXED)) dut_f (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_f),
        .mem       (mem_f),
        .grant_idx (grant_f),
        .busy      (busy_f)
    );

    mem_arbiter #(.N_PORTS(NR), .ARB_MODE(ARB_RR)) dut_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_r),
        .mem       (mem_r),
        .grant_idx (grant_r),
        .busy      (busy_r)
    );

    // Stimulus arrays, index 0 = fixed instance, 1 = round-robin instance.
    logic [3:0] rv  [2];
    addr_t      ra  [2][4];
    data_t      rw  [2][4];
    byte_en_t   rb  [2][4];
    logic       mr  [2];
    data_t      mrd [2];

    assign req_f.req_valid       = rv[0][1:0];
    assign req_f.req_addr        = {ra[0][1], ra[0][0]};
    assign req_f.req_wdata       = {rw[0][1], rw[0][0]};
    assign req_f.req_byte_enable = {rb[0][1], rb[0][0]};
    assign req_r.req_valid       = rv[1];
    assign req_r.req_addr        = {ra[1][3], ra[1][2], ra[1][1], ra[1][0]};
    assign req_r.req_wdata       = {rw[1][3], rw[1][2], rw[1][1], rw[1][0]};
    assign req_r.req_byte_enable = {rb[1][3], rb[1][2], rb[1][1], rb[1][0]};
    assign mem_f.mem_ready       = mr[0];
    assign mem_f.mem_rdata       = mrd[0];
    assign mem_r.mem_ready       = mr[1];
    assign mem_r.mem_rdata       = mrd[1];

    // Observation arrays.
    logic [3:0] o_ready  [2];
    data_t      o_rdata  [2];
    logic       o_mvalid [2];
    addr_t      o_maddr  [2];
    data_t      o_mwdata [2];
    byte_en_t   o_mbe    [2];
    logic [1:0] o_grant  [2];
    logic       o_busy   [2];

    assign o_ready[0]  = {2'b00, req_f.req_ready};
    assign o_ready[1]  = req_r.req_ready;
    assign o_rdata[0]  = req_f.req_rdata;
    assign o_rdata[1]  = req_r.req_rdata;
    assign o_mvalid[0] = mem_f.mem_valid;
    assign o_mvalid[1] = mem_r.mem_valid;
    assign o_maddr[0]  = mem_f.mem_addr;
    assign o_maddr[1]  = mem_r.mem_addr;
    assign o_mwdata[0] = mem_f.mem_wdata;
    assign o_mwdata[1] = mem_r.mem_wdata;
    assign o_mbe[0]    = mem_f.mem_byte_enable;
    assign o_mbe[1]    = mem_r.mem_byte_enable;
    assign o_grant[0]  = {1'b0, grant_f};
    assign o_grant[1]  = grant_r;
    assign o_busy[0]   = busy_f;
    assign o_busy[1]   = busy_r;

    int    tests_run    = 0;
    int    tests_failed = 0;
    int    done_cnt   [2];
    int    idle_req   [2];
    int    resp_delay [2];
    exp_t  exp_q0 [$];
    exp_t  exp_q1 [$];
    time   ready_times [$];
    data_t mem_model [addr_t];

    function automatic data_t model_rdata(input addr_t a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic push_exp(input int inst, input int port, input data_t d);
        exp_t e;
        e.port  = port;
        e.rdata = d;
        if (inst == 0) exp_q0.push_back(e);
        else           exp_q1.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int inst, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (done_cnt[inst] >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Memory model: answers resp_delay cycles into a transaction; can also
    // fire one stray mem_ready pulse on request.
    task automatic responder(input int inst);
        int cnt = 0;
        int ack = 0;
        forever begin
            tick();
            if (mr[inst]) begin
                mr[inst]  = 1'b0;
                mrd[inst] = '0;
                cnt       = 0;
            end else if (idle_req[inst] != ack) begin
                ack       = idle_req[inst];
                mr[inst]  = 1'b1;
                mrd[inst] = 32'hCAFE_F00D;
            end else if (o_mvalid[inst] === 1'b1 && rst_n) begin
                cnt++;
                if (cnt >= resp_delay[inst]) begin
                    mr[inst]  = 1'b1;
                    mrd[inst] = model_rdata(o_maddr[inst]);
                    cnt       = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    endtask

    // Scoreboard consumer: every ready pulse pops one expected completion.
    task automatic monitor(input int inst);
        exp_t e;
        bit   have;
        forever begin
            @(negedge clk);
            if (o_ready[inst] != 4'b0000) begin
                have = 1'b0;
                if (inst == 0 && exp_q0.size() > 0) begin
                    e = exp_q0.pop_front(); have = 1'b1;
                end else if (inst == 1 && exp_q1.size() > 0) begin
                    e = exp_q1.pop_front(); have = 1'b1;
                end
                tests_run++;
                if (!have) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected[%0d]: req_ready=%b, expected no completion", inst, o_ready[inst]);
                end else begin
                    tests_run++;
                    if (o_ready[inst] !== (4'b0001 << e.port)) begin
                        tests_failed++;
                        $display("FAIL sb_port[%0d]: req_ready=%b expected %b", inst, o_ready[inst], 4'b0001 << e.port);
                    end
                    tests_run++;
                    if (o_rdata[inst] !== e.rdata) begin
                        tests_failed++;
                        $display("FAIL sb_rdata[%0d]: req_rdata=%h expected %h", inst, o_rdata[inst], e.rdata);
                    end
                end
                done_cnt[inst]++;
                if (inst == 1) ready_times.push_back($time);
            end else begin
                tests_run++;
                if (o_rdata[inst] !== '0) begin
                    tests_failed++;
                    $display("FAIL idle_rdata[%0d]: req_rdata=%h expected 0", inst, o_rdata[inst]);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if ({o_mvalid[i], o_busy[i], o_ready[i]} !== 6'b0) begin
                tests_failed++;
                $display("FAIL reset_ctrl[%0d]: mem_valid=%b busy=%b req_ready=%b expected 0", i, o_mvalid[i], o_busy[i], o_ready[i]);
            end
            tests_run++;
            if ({o_maddr[i], o_mwdata[i], o_mbe[i], o_grant[i]} !== '0) begin
                tests_failed++;
                $display("FAIL reset_fields[%0d]: addr=%h wdata=%h be=%b grant=%0d expected 0", i, o_maddr[i], o_mwdata[i], o_mbe[i], o_grant[i]);
            end
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        int base;
        bit ok;
        base = done_cnt[0];
        mem_model[32'h100] = 32'hDEAD_BEEF;
        resp_delay[0] = 3;
        tick();
        ra[0][1] = 32'h100; rw[0][1] = '0; rb[0][1] = '0; rv[0][1] = 1'b1;
        push_exp(0, 1, 32'hDEAD_BEEF);
        @(negedge clk);
        tests_run++;
        if (o_mvalid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_latency_early: mem_valid=%b expected 0", o_mvalid[0]);
        end
        @(negedge clk);
        tests_run++;
        if ({o_mvalid[0], o_grant[0], o_maddr[0], o_mbe[0]} !== {1'b1, 2'd1, 32'h100, 4'b0000}) begin
            tests_failed++;
            $display("FAIL read_issue: mem_valid=%b grant=%0d addr=%h be=%b expected 1/1/100/0000", o_mvalid[0], o_grant[0], o_maddr[0], o_mbe[0]);
        end
        wait_done(0, base + 1, 20, ok);
        rv[0][1] = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL read_timeout: completions=%0d expected %0d", done_cnt[0] - base, 1);
        end
        repeat (4) tick();
        tests_run++;
        if (done_cnt[0] !== base + 1 || o_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_once: completions=%0d busy=%b expected 1/0", done_cnt[0] - base, o_busy[0]);
        end
    endtask

    task automatic test_write_fields();
        int base;
        bit ok;
        base = done_cnt[0];
        resp_delay[0] = 4;
        tick();
        ra[0][0] = 32'h40; rw[0][0] = 32'h1234_5678; rb[0][0] = 4'b0011; rv[0][0] = 1'b1;
        push_exp(0, 0, model_rdata(32'h40));
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if ({o_mvalid[0], o_maddr[0], o_mwdata[0], o_mbe[0]} !== {1'b1, 32'h40, 32'h1234_5678, 4'b0011}) begin
                tests_failed++;
                $display("FAIL write_fields cyc%0d: valid=%b addr=%h wdata=%h be=%b expected 1/40/12345678/0011", c, o_mvalid[0], o_maddr[0], o_mwdata[0], o_mbe[0]);
            end
        end
        wait_done(0, base + 1, 10, ok);
        rv[0][0] = 1'b0;
        rb[0][0] = '0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL write_timeout: completions=%0d expected 1", done_cnt[0] - base);
        end
    endtask

    task automatic test_fixed_priority();
        int base;
        bit ok;
        base = done_cnt[0];
        resp_delay[0] = 1;
        tick();
        ra[0][0] = 32'h200; ra[0][1] = 32'h300;
        rw[0][0] = '0; rw[0][1] = '0; rb[0][0] = '0; rb[0][1] = '0;
        rv[0] = 4'b0011;
        for (int k = 0; k < 4; k++) push_exp(0, 0, model_rdata(32'h200));
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (o_busy[0]) begin
                tests_run++;
                if (o_grant[0] !== 2'd0) begin
                    tests_failed++;
                    $display("FAIL fixed_grant: grant_idx=%0d expected 0", o_grant[0]);
                end
            end
            tick();
            if (done_cnt[0] >= base + 4) ok = 1'b1;
        end
        rv[0] = 4'b0000;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL fixed_timeout: completions=%0d expected 4", done_cnt[0] - base);
        end
    endtask

    task automatic test_rr_order();
        int       base;
        bit       ok;
        const int order [5] = '{0, 1, 2, 3, 0};
        base = done_cnt[1];
        resp_delay[1] = 1;
        ready_times.delete();
        tick();
        for (int p = 0; p < NR; p++) begin
            ra[1][p] = 32'h1000 + 32'(16 * p);
            rw[1][p] = '0;
            rb[1][p] = '0;
        end
        rv[1] = 4'b1111;
        for (int k = 0; k < 5; k++) push_exp(1, order[k], model_rdata(32'h1000 + 32'(16 * order[k])));
        wait_done(1, base + 5, 40, ok);
        rv[1] = 4'b0000;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rr_timeout: completions=%0d expected 5", done_cnt[1] - base);
        end
        tests_run++;
        if (ready_times.size() != 5) begin
            tests_failed++;
            $display("FAIL rr_count: pulses=%0d expected 5", ready_times.size());
        end
        for (int k = 1; k < ready_times.size(); k++) begin
            tests_run++;
            if (ready_times[k] - ready_times[k-1] !== 2 * CLK_P) begin
                tests_failed++;
                $display("FAIL rr_spacing[%0d]: gap=%0t expected %0t", k, ready_times[k] - ready_times[k-1], 2 * CLK_P);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        base = done_cnt[0];
        resp_delay[0] = 5;
        tick();
        ra[0][0] = 32'h80; rw[0][0] = '0; rb[0][0] = '0; rv[0][0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        tests_run++;
        if (o_busy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_pre: busy=%b expected 1", o_busy[0]);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_mvalid[0], o_busy[0], o_ready[0]} !== 6'b0) begin
            tests_failed++;
            $display("FAIL rstmid_ctrl: mem_valid=%b busy=%b req_ready=%b expected 0", o_mvalid[0], o_busy[0], o_ready[0]);
        end
        tests_run++;
        if ({o_maddr[0], o_grant[0]} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_fields: addr=%h grant=%0d expected 0", o_maddr[0], o_grant[0]);
        end
        @(negedge clk);
        tick();
        push_exp(0, 0, model_rdata(32'h80));
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (o_mvalid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_release: mem_valid=%b expected 0 before first edge", o_mvalid[0]);
        end
        @(negedge clk);
        tests_run++;
        if ({o_mvalid[0], o_grant[0], o_maddr[0]} !== {1'b1, 2'd0, 32'h80}) begin
            tests_failed++;
            $display("FAIL rstmid_regrant: valid=%b grant=%0d addr=%h expected 1/0/80", o_mvalid[0], o_grant[0], o_maddr[0]);
        end
        wait_done(0, base + 1, 20, ok);
        rv[0][0] = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rstmid_timeout: completions=%0d expected 1", done_cnt[0] - base);
        end
    endtask

    task automatic test_idle_ready();
        int base;
        bit saw;
        base = done_cnt[0];
        tick();
        tests_run++;
        if (o_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_pre: busy=%b expected 0", o_busy[0]);
        end
        idle_req[0]++;
        saw = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            saw |= mr[0];
            tests_run++;
            if ({o_ready[0], o_busy[0], o_mvalid[0]} !== 6'b0) begin
                tests_failed++;
                $display("FAIL idle_ready cyc%0d: req_ready=%b busy=%b mem_valid=%b expected 0", c, o_ready[0], o_busy[0], o_mvalid[0]);
            end
        end
        tests_run++;
        if (!saw) begin
            tests_failed++;
            $display("FAIL idle_stim: mem_ready=0 expected a pulse");
        end
        tests_run++;
        if (done_cnt[0] !== base) begin
            tests_failed++;
            $display("FAIL idle_count: completions=%0d expected 0", done_cnt[0] - base);
        end
    endtask

    task automatic test_drain();
        repeat (3) tick();
        tests_run++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: outstanding=%0d/%0d expected 0/0", exp_q0.size(), exp_q1.size());
        end
    endtask

    initial begin
        #(CLK_P * 20000);
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = '0; mr[i] = 1'b0; mrd[i] = '0;
            done_cnt[i] = 0; idle_req[i] = 0; resp_delay[i] = 1;
            for (int p = 0; p < 4; p++) begin
                ra[i][p] = '0; rw[i][p] = '0; rb[i][p] = '0;
            end
        end
        #1 rst_n = 1'b0;
        fork
            responder(0);
            responder(1);
            monitor(0);
            monitor(1);
        join_none

        test_reset();
        test_single_read();
        test_write_fields();
        test_fixed_priority();
        test_rr_order();
        test_reset_mid();
        test_idle_ready();
        test_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_mem_arbiter
